// File: rtl/wl_pkg.sv
// Shared types and defaults for the word-line pulse controller and the read-path column mux.
package wl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRECH = 2'd1,
    PULSE = 2'd2
  } wl_state_e;

  localparam int WL_ADR_W_DEF     = 4;
  localparam int WL_ROWS_DEF      = 2 ** WL_ADR_W_DEF;
  localparam int WL_PRECH_CYC_DEF = 1;
  localparam int WL_PULSE_CYC_DEF = 2;

  function automatic logic [WL_ROWS_DEF-1:0] onehot(input logic [WL_ADR_W_DEF-1:0] adr);
    logic [WL_ROWS_DEF-1:0] v;
    v      = '0;
    v[adr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wl_pulse_ctrl_decoder.sv
// Combinational ADR_W-to-ROWS one-hot decoder with enable; all-zero when disabled.
module wl_decoder
  import wl_pkg::*;
#(
  parameter int ADR_W = WL_ADR_W_DEF
) (
  input  logic                  i_en,
  input  logic [ADR_W-1:0]      i_adr,
  output logic [(2**ADR_W)-1:0] o_wl
);

  generate
    if (ADR_W == WL_ADR_W_DEF) begin : g_shared
      // Default geometry reuses the same decode as the read-path column mux.
      always_comb begin
        o_wl = '0;
        if (i_en) o_wl = onehot(i_adr);
      end
    end else begin : g_generic
      always_comb begin
        o_wl = '0;
        if (i_en) o_wl[i_adr] = 1'b1;
      end
    end
  endgenerate

endmodule

// File: rtl/wl_pulse_ctrl.sv
// Timed word-line generator: accepts one row access, precharges bit lines, then pulses one word line.
module wl_pulse_ctrl
  import wl_pkg::*;
#(
  parameter int ADR_W     = WL_ADR_W_DEF,
  parameter int PRECH_CYC = WL_PRECH_CYC_DEF,
  parameter int PULSE_CYC = WL_PULSE_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADR_W-1:0]      ADR,
  input  logic                  req_we,
  output logic                  PRE,
  output logic [(2**ADR_W)-1:0] WL,
  output logic                  WE,
  output logic                  done,
  output logic [1:0]            o_state
);

  localparam int ROWS = 2 ** ADR_W;
  localparam int MAXC = (PRECH_CYC > PULSE_CYC) ? PRECH_CYC : PULSE_CYC;
  localparam int CW   = (MAXC <= 1) ? 1 : $clog2(MAXC + 1);
  localparam logic [CW-1:0] PRECH_LD = (PRECH_CYC > 0) ? CW'(PRECH_CYC - 1) : '0;
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE and a transferred request cannot be withdrawn.
  wl_state_e         r_state;
  logic [CW-1:0]     r_cnt;
  logic [ADR_W-1:0]  r_adr;
  logic              r_we_lat;
  logic              r_pre;
  logic [ROWS-1:0]   r_wl;
  logic              r_we;
  logic              r_done;

  wl_state_e         w_state_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [ADR_W-1:0]  w_adr_nxt;
  logic              w_we_nxt;
  logic [ROWS-1:0]   w_wl_dec;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_adr_nxt   = r_adr;
    w_we_nxt    = r_we_lat;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_adr_nxt = ADR;
          w_we_nxt  = req_we;
          if (PRECH_CYC == 0) begin
            w_state_nxt = PULSE;
            w_cnt_nxt   = PULSE_LD;
          end else begin
            w_state_nxt = PRECH;
            w_cnt_nxt   = PRECH_LD;
          end
        end
      end
      PRECH: begin
        if (r_cnt == '0) begin
          w_state_nxt = PULSE;
          w_cnt_nxt   = PULSE_LD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      PULSE: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Decode from next-state so WL rises on the same edge the FSM enters PULSE.
  wl_decoder #(.ADR_W(ADR_W)) u_dec (
    .i_en  (w_state_nxt == PULSE),
    .i_adr (w_adr_nxt),
    .o_wl  (w_wl_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_adr    <= '0;
      r_we_lat <= 1'b0;
      r_pre    <= 1'b0;
      r_wl     <= '0;
      r_we     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_adr    <= w_adr_nxt;
      r_we_lat <= w_we_nxt;
      r_pre    <= (w_state_nxt == PRECH);
      r_wl     <= w_wl_dec;
      r_we     <= (w_state_nxt == PULSE) && w_we_nxt;
      r_done   <= (r_state == PULSE) && (r_cnt == '0);
    end
  end

  assign req_ready = (r_state == IDLE);
  assign PRE       = r_pre;
  assign WL        = r_wl;
  assign WE        = r_we;
  assign done      = r_done;
  assign o_state   = r_state;

endmodule
